cond_unit: RTL and testbench
============================

Name: cond_unit

Overview:
- Condition-execution stage directly downstream of the instruction decoder.
- Holds the architectural NZCV flag register and evaluates the 4-bit instruction condition field against it.
- Gates the decoder's PCS/RegW/MemW strobes into the final PCSrc/RegWrite/MemWrite enables.
- Updates flags from the ALU under decoder FlagW control, only when the instruction actually executes.

Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.
- CNT_W, 16, width of the performance counters; used only with COND_PERF_CNT_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- valid  in  1  an instruction is present this cycle.
- stall  in  1  pipeline hold; the instruction must not commit.
- Cond  in  4  instruction condition field, bits [31:28].
- ALUFlags  in  4  ALU result flags {N,Z,C,V}.
- FlagW  in  2  from decoder; [1] enables N,Z write, [0] enables C,V write.
- PCS  in  1  from decoder; PC-write request.
- RegW  in  1  from decoder; register-write request.
- MemW  in  1  from decoder; memory-write request.
- CondEx  out  1  condition passes against the current Flags.
- PCSrc  out  1  gated PC write.
- RegWrite  out  1  gated register write.
- MemWrite  out  1  gated memory write.
- Flags  out  4  registered {N,Z,C,V}.
- ExecCnt  out  CNT_W  executed-instruction count; present only with the feature.
- SkipCnt  out  CNT_W  squashed-instruction count; present only with the feature.

Behaviour:
- Flag bit order, Flags and ALUFlags: [3]=N, [2]=Z, [1]=C, [0]=V.
- CondEx is combinational from Cond and the registered Flags, never from ALUFlags:
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !(C&!Z).
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: !(!Z&(N==V)).
  - 1110 AL: 1. 1111: treated as 1.
- Commit: go = valid & !stall & reset_n & CondEx.
  - PCSrc = PCS & go; RegWrite = RegW & go; MemWrite = MemW & go.
  - All three are combinational, with zero latency.
- While reset_n is low, PCSrc, RegWrite and MemWrite are 0 regardless of other inputs.
- Flag update at a rising edge when go=1:
  - FlagW[1]=1: Flags[3:2] <= ALUFlags[3:2].
  - FlagW[0]=1: Flags[1:0] <= ALUFlags[1:0].
  - Bits not enabled hold their value.
- Updated flags are visible to CondEx from the next cycle. There is no same-cycle forwarding.
- Squashed instructions (valid=1, CondEx=0) update no flags and assert no strobe.
- stall=1 blocks flag update and all strobes. The same instruction re-evaluates when stall drops.
- valid=0: no update and no strobes. CondEx still reflects Cond against Flags.
- Reset: on a rising edge with reset_n=0, Flags <= RESET_FLAGS and counters <= 0.
  - Reset has priority over a simultaneous flag write.
  - Reset mid-stream discards the in-flight instruction's effects.
- Decoder X on FlagW for non-DP instructions is not expected; the decoder drives 00. An X on FlagW when go=0 must not corrupt Flags.

Optional Feature:
- Macro: COND_PERF_CNT_EN.
- Defined:
  - ExecCnt increments on each edge where valid & !stall & CondEx.
  - SkipCnt increments on each edge where valid & !stall & !CondEx.
  - Both are CNT_W bits, saturate at all-ones (no wrap), and clear on reset.
  - Stalled cycles are not counted.
- Undefined: ExecCnt/SkipCnt ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then Cond=1110, RegW=1, valid=1 -> Flags=0000, RegWrite=1. Repeat with reset_n=0 held -> RegWrite=0.
- Flags=0000, Cond=0000 (EQ), valid=1, RegW=1, MemW=1 -> CondEx=0, RegWrite=0, MemWrite=0. Flags unchanged even with FlagW=11, ALUFlags=1111.
- Cond=1110, FlagW=10, ALUFlags=0110 -> next cycle Flags=0100. Then FlagW=01, ALUFlags=1011 -> Flags=0111 (N,Z held).
- Flags=1001 (N=1, V=1): Cond=1010 GE -> CondEx=1; 1011 LT -> 0; 1100 GT -> 1. Flags=0100: 1101 LE -> 1; 1000 HI -> 0.
- stall=1, Cond=1110, PCS=1, FlagW=11, ALUFlags=1111 for 3 cycles -> PCSrc=0 and Flags unchanged. stall drops -> PCSrc=1 and Flags=1111 next cycle.
- With COND_PERF_CNT_EN and CNT_W=4:
  - 5 executed + 3 squashed + 2 stalled instructions -> ExecCnt=5, SkipCnt=3.
  - 20 more executed -> ExecCnt=15, saturated.
  - Reset -> both 0.

Source files
------------

// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register and condition-execution gate for the decoder's PCS/RegW/MemW strobes.
// Define COND_PERF_CNT_EN to add saturating ExecCnt/SkipCnt performance counters.
module cond_unit #(
    parameter logic [3:0]  RESET_FLAGS = 4'b0000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic             stall,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    output logic             CondEx,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
`ifdef COND_PERF_CNT_EN
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SkipCnt,
`endif
    output logic [3:0]       Flags
);

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, r;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = c;
            4'b0011: r = ~c;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = c & ~z;
            4'b1001: r = ~(c & ~z);
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = ~(~z & (n == v));
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    logic [3:0] flags_q, flags_d;
    logic       cond_ex_s, go_s;

    // Condition check uses only the registered flags, so ALU results affect the next instruction.
    always_comb begin
        cond_ex_s = cond_eval(Cond, flags_q);
        go_s      = valid & ~stall & reset_n & cond_ex_s;
    end

    assign CondEx   = cond_ex_s;
    assign PCSrc    = PCS  & go_s;
    assign RegWrite = RegW & go_s;
    assign MemWrite = MemW & go_s;
    assign Flags    = flags_q;

    // FlagW is only looked at once the instruction commits, so an X there cannot leak in.
    always_comb begin
        flags_d = flags_q;
        if (go_s) begin
            if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
            else          flags_d[3:2] = flags_q[3:2];
            if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
            else          flags_d[1:0] = flags_q[1:0];
        end else begin
            flags_d = flags_q;
        end
    end

    // Flag register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) flags_q <= RESET_FLAGS;
        else          flags_q <= flags_d;
    end

`ifdef COND_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;

    // Saturating counters; stalled cycles are neither executed nor skipped.
    always_comb begin
        exec_cnt_d = exec_cnt_q;
        skip_cnt_d = skip_cnt_q;
        if (valid && !stall) begin
            if (cond_ex_s) begin
                if (exec_cnt_q != CNT_MAX) exec_cnt_d = exec_cnt_q + CNT_ONE;
                else                       exec_cnt_d = exec_cnt_q;
            end else begin
                if (skip_cnt_q != CNT_MAX) skip_cnt_d = skip_cnt_q + CNT_ONE;
                else                       skip_cnt_d = skip_cnt_q;
            end
        end else begin
            exec_cnt_d = exec_cnt_q;
            skip_cnt_d = skip_cnt_q;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            exec_cnt_q <= '0;
            skip_cnt_q <= '0;
        end else begin
            exec_cnt_q <= exec_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign ExecCnt = exec_cnt_q;
    assign SkipCnt = skip_cnt_q;
`else
    localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit; counter checks are built when COND_PERF_CNT_EN is defined.
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset_n, valid, stall, PCS, RegW, MemW;
    logic [3:0] Cond, ALUFlags;
    logic [1:0] FlagW;
    logic       CondEx, PCSrc, RegWrite, MemWrite;
    logic [3:0] Flags;
`ifdef COND_PERF_CNT_EN
    logic [3:0] exec_cnt, skip_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [3:0]  flag_vals [3];
    logic [15:0] cond_tbl  [3];

    always #5 clk = ~clk;

    cond_unit #(.RESET_FLAGS(4'b0000), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .valid(valid), .stall(stall),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
`ifdef COND_PERF_CNT_EN
        .ExecCnt(exec_cnt), .SkipCnt(skip_cnt),
`endif
        .Flags(Flags)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one instruction at the falling edge; it commits at the following rising edge.
    task automatic drive(input logic v, input logic s, input logic [3:0] c, input logic [3:0] a,
                         input logic [1:0] fw, input logic p, input logic r, input logic m);
        @(negedge clk);
        valid = v; stall = s; Cond = c; ALUFlags = a; FlagW = fw;
        PCS = p; RegW = r; MemW = m;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_flags(input logic [3:0] f);
        drive(1'b1, 1'b0, 4'hE, f, 2'b11, 1'b0, 1'b0, 1'b0);
        idle();
        check_val("set_flags", 16'(Flags), 16'(f));
    endtask

    initial begin
        flag_vals[0] = 4'b0100; cond_tbl[0] = 16'hE6A9;
        flag_vals[1] = 4'b1001; cond_tbl[1] = 16'hD65A;
        flag_vals[2] = 4'b0010; cond_tbl[2] = 16'hD5A6;

        reset_n = 1'b0; valid = 1'b0; stall = 1'b0; Cond = 4'h0; ALUFlags = 4'h0;
        FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;

        // Reset held with a would-be committing instruction.
        drive(1'b1, 1'b0, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1);
        check_val("rst_flags", 16'(Flags), 16'h0);
        check_val("rst_pcsrc", 16'(PCSrc), 16'h0);
        check_val("rst_memwrite", 16'(MemWrite), 16'h0);
        check_val("rst_condex", 16'(CondEx), 16'h1);
        drive(1'b1, 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
        check_val("rst_regwrite", 16'(RegWrite), 16'h0);
        reset_n = 1'b1;
        #1;
        check_val("al_regwrite", 16'(RegWrite), 16'h1);
        check_val("al_flags", 16'(Flags), 16'h0);

        // EQ with Z=0 squashes strobes and flag write.
        drive(1'b1, 1'b0, 4'h0, 4'hF, 2'b11, 1'b0, 1'b1, 1'b1);
        check_val("eq_condex", 16'(CondEx), 16'h0);
        check_val("eq_regwrite", 16'(RegWrite), 16'h0);
        check_val("eq_memwrite", 16'(MemWrite), 16'h0);
        idle();
        check_val("eq_flags", 16'(Flags), 16'h0);

        // Partial flag writes.
        drive(1'b1, 1'b0, 4'hE, 4'b0110, 2'b10, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 4'hE, 4'b1011, 2'b01, 1'b0, 1'b0, 1'b0);
        check_val("flagw_nz", 16'(Flags), 16'b0100);
        drive(1'b1, 1'b0, 4'h0, 4'b0000, 2'b11, 1'b0, 1'b1, 1'b0);
        check_val("flagw_cv", 16'(Flags), 16'b0111);
        check_val("no_fwd_condex", 16'(CondEx), 16'h1);
        check_val("no_fwd_regwrite", 16'(RegWrite), 16'h1);
        idle();
        check_val("fwd_update", 16'(Flags), 16'h0);

        // Squashed instruction with unknown FlagW must leave flags alone.
        drive(1'b1, 1'b0, 4'h0, 4'hF, 2'bxx, 1'b0, 1'b0, 1'b0);
        check_val("x_condex", 16'(CondEx), 16'h0);
        idle();
        check_val("x_flagw_hold", 16'(Flags), 16'h0);

        // Full condition table against three flag settings, valid=0.
        for (int k = 0; k < 3; k++) begin
            set_flags(flag_vals[k]);
            for (int c = 0; c < 16; c++) begin
                drive(1'b0, 1'b0, 4'(c), 4'h0, 2'b00, 1'b1, 1'b1, 1'b1);
                check_val($sformatf("cond_f%0h_c%0h", flag_vals[k], c), 16'(CondEx), 16'(cond_tbl[k][c]));
            end
            check_val("valid0_regwrite", 16'(RegWrite), 16'h0);
        end

        // Stall blocks strobes and flag update, then the same instruction commits.
        set_flags(4'b0000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 4'hE, 4'hF, 2'b11, 1'b1, 1'b0, 1'b0);
            check_val("stall_pcsrc", 16'(PCSrc), 16'h0);
            check_val("stall_flags", 16'(Flags), 16'h0);
        end
        drive(1'b1, 1'b0, 4'hE, 4'hF, 2'b11, 1'b1, 1'b0, 1'b0);
        check_val("unstall_pcsrc", 16'(PCSrc), 16'h1);
        check_val("unstall_flags_old", 16'(Flags), 16'h0);
        idle();
        check_val("unstall_flags_new", 16'(Flags), 16'hF);

        // Reset mid-stream beats a simultaneous flag write.
        drive(1'b1, 1'b0, 4'hE, 4'hA, 2'b11, 1'b1, 1'b1, 1'b1);
        reset_n = 1'b0;
        #1;
        check_val("rst_mid_pcsrc", 16'(PCSrc), 16'h0);
        check_val("rst_mid_regwrite", 16'(RegWrite), 16'h0);
        check_val("rst_mid_memwrite", 16'(MemWrite), 16'h0);
        idle();
        check_val("rst_prio_flags", 16'(Flags), 16'h0);
        reset_n = 1'b1;

`ifdef COND_PERF_CNT_EN
        check_val("cnt_rst_exec", 16'(exec_cnt), 16'h0);
        check_val("cnt_rst_skip", 16'(skip_cnt), 16'h0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        idle();
        check_val("cnt_exec5", 16'(exec_cnt), 16'h5);
        check_val("cnt_skip3", 16'(skip_cnt), 16'h3);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        idle();
        check_val("cnt_exec_sat", 16'(exec_cnt), 16'hF);
        check_val("cnt_skip_hold", 16'(skip_cnt), 16'h3);
        reset_n = 1'b0;
        idle();
        check_val("cnt_clr_exec", 16'(exec_cnt), 16'h0);
        check_val("cnt_clr_skip", 16'(skip_cnt), 16'h0);
        reset_n = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
